ins_fetch_unit: RTL and testbench
=================================

// Module: ins_fetch_unit
// PURPOSE
//  Instruction fetch unit: owns the PC, issues in-order requests to instruction memory,
//  buffers returned words and supplies ins_IF_ID with instruction + PC. Drops in-flight
//  fetches on a redirect (taken branch/jump from ID/EX). ins_valid=0 presents all-zero
//  ins_data, the same NOP encoding IF_flush loads into IF/ID.
// PARAMETERS
//  INS_W      32  instruction width
//  PC_W       32  program counter / address width
//  RESET_PC   0   PC after reset (word aligned)
//  BUF_DEPTH  2   instruction buffer entries; also max requests in flight (>=1)
// PORTS
//  clk          in   1      clock, all state on rising edge
//  arst         in   1      asynchronous, active-high reset
//  imem_req     out  1      one fetch request issued this cycle
//  imem_addr    out  PC_W   fetch address, valid with imem_req
//  imem_rvalid  in   1      response word valid (in order, >=1 cycle after request)
//  imem_rdata   in   INS_W  response word
//  id_ready     in   1      IF/ID enable; head instruction consumed when ins_valid=1
//  ins_valid    out  1      buffer head is valid
//  ins_data     out  INS_W  head instruction; all-zero when ins_valid=0
//  ins_pc       out  PC_W   PC of head instruction; 0 when ins_valid=0
//  redirect     in   1      taken branch/jump: discard all fetched/in-flight work
//  redirect_pc  in   PC_W   new PC; bits [1:0] ignored (treated as 0)
// BEHAVIOUR
//  Reset (arst=1, async): pc=RESET_PC, buffer empty, outstanding=0, drop_cnt=0;
//   imem_req=0, imem_addr=0, ins_valid=0, ins_data=0, ins_pc=0. Reset mid-flight
//   discards everything; later rvalid with outstanding=0 is ignored.
//  Counters: outstanding, drop_cnt and buffer count are $clog2(BUF_DEPTH+1) bits.
//  Issue (registered outputs): request when outstanding+count < BUF_DEPTH, counting
//   this cycle's pop, and redirect=0. Next cycle imem_req=1, imem_addr=pc;
//   pc += 4 (wraps modulo 2^PC_W); outstanding += 1. Max one request per cycle.
//  Response: imem_rvalid with drop_cnt>0 -> word discarded, drop_cnt -= 1.
//   Otherwise word+its PC written at buffer tail, outstanding -= 1.
//   Latency: rvalid at edge t -> ins_valid=1 after edge t+1 (no bypass).
//  Consume: id_ready=1 && ins_valid=1 -> head popped at the edge. Read/write same edge
//   allowed at any fill level. Overflow impossible by issue rule; rvalid with
//   outstanding=0 and drop_cnt=0 is ignored.
//  Redirect (highest priority): at the edge pc <= {redirect_pc[PC_W-1:2],2'b00};
//   buffer cleared; pop and buffer write that cycle suppressed; drop_cnt <=
//   drop_cnt + outstanding - (rvalid that cycle ? 1 : 0); outstanding <= 0; no
//   request issued that cycle. First request to new pc issued the following cycle.
//  Back-to-back redirects: each accumulates drop_cnt as above; only latest pc kept.
//  id_ready=0: buffer holds, issuing stops once outstanding+count=BUF_DEPTH.
//  Sequence per redirect: IDLE-like drain (drop_cnt>0, new requests allowed
//   concurrently) -> FETCH; no explicit FSM states beyond these counters required.
// TESTING
//  1 Reset release, memory latency 1, id_ready=1 -> imem_addr 0,4,8,... one per cycle;
//    ins_pc/ins_data stream in order, ins_valid first high 3 cycles after reset release.
//  2 id_ready=0 for 10 cycles, BUF_DEPTH=2 -> exactly 2 requests outstanding/buffered,
//    imem_req stays 0; id_ready=1 -> words for PC 0x0,0x4 delivered, no loss/duplicate.
//  3 Memory latency 3, redirect to 0x100 with 2 in flight -> both late words dropped,
//    next ins_valid shows ins_pc=0x100; no stale PC ever visible.
//  4 Redirect same cycle as pop and rvalid -> pop suppressed, word dropped, drop_cnt
//    accounts for it; redirect_pc=0x103 fetched as 0x100.
//  5 arst asserted mid-stream with 2 in flight -> all outputs 0 immediately (async);
//    stray rvalid after release ignored; fetch restarts at RESET_PC.
//  6 PC_W=8, RESET_PC=0xF8 -> addresses 0xF8,0xFC,0x00 (wrap), data ordering intact.

Source files
------------

// File: rtl/ins_fetch_unit.sv
// rtl/ins_fetch_unit.sv - instruction fetch unit: PC, in-order imem requests, head buffer, redirect drop accounting
module ins_fetch_unit #(
    parameter int              INS_W     = 32,
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             arst,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_rvalid,
    input  logic [INS_W-1:0] imem_rdata,
    input  logic             id_ready,
    output logic             ins_valid,
    output logic [INS_W-1:0] ins_data,
    output logic [PC_W-1:0]  ins_pc,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(BUF_DEPTH - 1);

    // pc is the next address to request; resp_pc is the PC of the next word that will be kept
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  resp_pc;
    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    drop_cnt;
    logic [CW-1:0]    count;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [INS_W-1:0] buf_data [BUF_DEPTH];
    logic [PC_W-1:0]  buf_pc   [BUF_DEPTH];

    logic             pop;
    logic             resp_drop;
    logic             resp_take;
    logic             live_resp;
    logic             issue;
    logic [CW:0]      occupancy;
    logic [PC_W-1:0]  target;

    // Head presentation: an empty buffer shows the all-zero NOP with PC 0
    assign ins_valid = (count != '0);
    assign ins_data  = ins_valid ? buf_data[head] : '0;
    assign ins_pc    = ins_valid ? buf_pc[head]   : '0;

    // Per-cycle decisions: pop, response classification, issue credit and aligned redirect target
    always_comb begin
        pop       = id_ready && ins_valid && !redirect;
        resp_drop = imem_rvalid && (drop_cnt != '0);
        resp_take = imem_rvalid && (drop_cnt == '0) && (outstanding != '0);
        // a response is only real if something is in flight; strays are ignored everywhere
        live_resp = resp_drop || resp_take;
        // slots are freed by this cycle's pop so a full buffer can keep streaming
        occupancy = {1'b0, outstanding} + {1'b0, count} - (CW+1)'(pop);
        issue     = !redirect && (occupancy < (CW+1)'(BUF_DEPTH));
        target    = {redirect_pc[PC_W-1:2], 2'b00};
    end

    // Control state: PC, request outputs, flight/drop counters and buffer pointers
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
        end else if (redirect) begin
            // everything already requested becomes a word to throw away
            pc          <= target;
            resp_pc     <= target;
            imem_req    <= 1'b0;
            drop_cnt    <= drop_cnt + outstanding - CW'(live_resp);
            outstanding <= '0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
        end else begin
            imem_req    <= issue;
            if (issue) begin
                imem_addr <= pc;
                pc        <= pc + PC_W'(4);
            end
            outstanding <= outstanding + CW'(issue) - CW'(resp_take);
            drop_cnt    <= drop_cnt - CW'(resp_drop);
            count       <= count + CW'(resp_take) - CW'(pop);
            if (resp_take) begin
                resp_pc <= resp_pc + PC_W'(4);
                tail    <= (tail == LAST) ? '0 : tail + 1'b1;
            end
            if (pop) begin
                head <= (head == LAST) ? '0 : head + 1'b1;
            end
        end
    end

    // Buffer storage: kept words are written at the tail together with their PC
    always_ff @(posedge clk) begin
        if (!arst && !redirect && resp_take) begin
            buf_data[tail] <= imem_rdata;
            buf_pc[tail]   <= resp_pc;
        end
    end

endmodule

// File: tb/tb_ins_fetch_unit.sv
// tb/tb_ins_fetch_unit.sv - self-checking bench for ins_fetch_unit with memory and stream reference models
module tb_ins_fetch_unit;

    logic        clk = 1'b0;
    logic        arst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_ready;
    logic        ins_valid;
    logic [31:0] ins_data;
    logic [31:0] ins_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        req8;
    logic [7:0]  addr8;
    logic        rvalid8;
    logic [31:0] rdata8;
    logic        valid8;
    logic [31:0] data8;
    logic [7:0]  pc8;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ins_fetch_unit #(.INS_W(32), .PC_W(32), .RESET_PC(32'h0), .BUF_DEPTH(2)) u_dut (
        .clk(clk), .arst(arst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_ready(id_ready),
        .ins_valid(ins_valid), .ins_data(ins_data), .ins_pc(ins_pc),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    ins_fetch_unit #(.INS_W(32), .PC_W(8), .RESET_PC(8'hF8), .BUF_DEPTH(2)) u_dut8 (
        .clk(clk), .arst(arst),
        .imem_req(req8), .imem_addr(addr8),
        .imem_rvalid(rvalid8), .imem_rdata(rdata8),
        .id_ready(1'b1),
        .ins_valid(valid8), .ins_data(data8), .ins_pc(pc8),
        .redirect(1'b0), .redirect_pc(8'h00)
    );

    // Memory content: a scrambled function of the address
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // In-order memory with programmable latency; strays rvalid while reset is held
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    always @(posedge clk) begin : mem
        logic        r;
        logic [31:0] a;
        int          d;
        r   = imem_req;
        a   = imem_addr;
        cyc = cyc + 1;
        #1;
        if (arst) begin
            mq_addr.delete();
            mq_due.delete();
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEADBEEF;
        end else begin
            if (r) begin
                d = cyc + lat - 1;
                if (mq_due.size() > 0 && d <= mq_due[$]) d = mq_due[$] + 1;
                mq_addr.push_back(a);
                mq_due.push_back(d);
            end
            if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word_of(mq_addr[0]);
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
        end
    end

    // Latency-1 memory for the narrow-PC instance
    always @(posedge clk) begin : mem8
        logic       r;
        logic [7:0] a;
        r = req8;
        a = addr8;
        #1;
        rvalid8 = r && !arst;
        rdata8  = word_of({24'h0, a});
    end

    // Observer: logs consumed instructions tagged with the current fetch target and
    // their position after it, plus every issued address
    logic [31:0] cur_base = 32'h0;
    int          kk = 0;
    logic [31:0] got_base[$];
    int          got_k[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_data[$];
    logic [31:0] iss_q[$];
    int          idle_bad = 0;
    always @(negedge clk) begin : mon
        if (arst) begin
            cur_base = 32'h0;
            kk       = 0;
        end else begin
            if (imem_req) iss_q.push_back(imem_addr);
            if (redirect) begin
                cur_base = redirect_pc & 32'hFFFF_FFFC;
                kk       = 0;
            end else if (id_ready && ins_valid) begin
                got_base.push_back(cur_base);
                got_k.push_back(kk);
                got_pc.push_back(ins_pc);
                got_data.push_back(ins_data);
                kk = kk + 1;
            end
        end
        if (!ins_valid && (ins_data !== 32'h0 || ins_pc !== 32'h0)) idle_bad = idle_bad + 1;
    end

    task automatic apply_reset();
        arst        = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        arst = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        vectors++;
        if (imem_req !== 1'b0) begin $display("FAIL reset_imem_req: got %b, required 0", imem_req); miscompares++; end
        vectors++;
        if (imem_addr !== 32'h0) begin $display("FAIL reset_imem_addr: got %h, required 0", imem_addr); miscompares++; end
        vectors++;
        if (ins_valid !== 1'b0) begin $display("FAIL reset_ins_valid: got %b, required 0", ins_valid); miscompares++; end
        vectors++;
        if (ins_data !== 32'h0 || ins_pc !== 32'h0) begin
            $display("FAIL reset_ins: got data=%h pc=%h, required 0/0", ins_data, ins_pc); miscompares++;
        end
    endtask

    task automatic test_stream();
        int gs;
        int is;
        lat = 1;
        apply_reset();
        id_ready = 1'b1;
        gs = got_pc.size();
        is = iss_q.size();
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #2;
            vectors++;
            if (ins_valid !== (c == 3)) begin
                $display("FAIL stream_first_valid cycle %0d: got %b, required %b", c, ins_valid, (c == 3)); miscompares++;
            end
        end
        repeat (30) @(posedge clk);
        vectors++;
        if (got_pc.size() - gs < 15) begin $display("FAIL stream_throughput: got %0d words, required >=15", got_pc.size() - gs); miscompares++; end
        for (int i = is; i < iss_q.size(); i++) begin
            vectors++;
            if (iss_q[i] !== 32'(4 * (i - is))) begin
                $display("FAIL stream_addr #%0d: got %h, required %h", i - is, iss_q[i], 32'(4 * (i - is))); miscompares++;
            end
        end
        for (int i = gs; i < got_pc.size(); i++) begin
            logic [31:0] e;
            e = 32'(4 * (i - gs));
            vectors++;
            if (got_pc[i] !== e || got_data[i] !== word_of(e)) begin
                $display("FAIL stream_word #%0d: got pc=%h data=%h, required pc=%h data=%h", i - gs, got_pc[i], got_data[i], e, word_of(e)); miscompares++;
            end
        end
    endtask

    task automatic test_stall();
        int gs;
        int is;
        lat = 1;
        apply_reset();
        gs = got_pc.size();
        is = iss_q.size();
        repeat (10) @(posedge clk);
        #2;
        vectors++;
        if (iss_q.size() - is != 2) begin $display("FAIL stall_requests: got %0d, required 2", iss_q.size() - is); miscompares++; end
        vectors++;
        if (imem_req !== 1'b0 || ins_valid !== 1'b1) begin
            $display("FAIL stall_hold: got req=%b valid=%b, required 0/1", imem_req, ins_valid); miscompares++;
        end
        id_ready = 1'b1;
        repeat (12) @(posedge clk);
        vectors++;
        if (got_pc.size() - gs < 4) begin $display("FAIL stall_resume: got %0d words, required >=4", got_pc.size() - gs); miscompares++; end
        for (int i = gs; i < got_pc.size(); i++) begin
            logic [31:0] e;
            e = 32'(4 * (i - gs));
            vectors++;
            if (got_pc[i] !== e || got_data[i] !== word_of(e)) begin
                $display("FAIL stall_word #%0d: got pc=%h data=%h, required pc=%h data=%h", i - gs, got_pc[i], got_data[i], e, word_of(e)); miscompares++;
            end
        end
    endtask

    task automatic test_redirect_inflight();
        int gs;
        int n;
        lat = 3;
        apply_reset();
        id_ready = 1'b1;
        n = 0;
        while (mq_addr.size() != 2 && n < 50) begin @(posedge clk); #2; n++; end
        vectors++;
        if (mq_addr.size() != 2) begin $display("FAIL inflight_wait: got %0d in flight, required 2", mq_addr.size()); miscompares++; end
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        gs = got_pc.size();
        @(posedge clk);
        #2;
        redirect = 1'b0;
        repeat (30) @(posedge clk);
        vectors++;
        if (got_pc.size() <= gs || got_pc[gs] !== 32'h100) begin
            $display("FAIL inflight_first_pc: got %0d words, first pc=%h, required 100", got_pc.size() - gs, (got_pc.size() > gs) ? got_pc[gs] : 32'h0); miscompares++;
        end
        for (int i = gs; i < got_pc.size(); i++) begin
            logic [31:0] e;
            e = 32'h100 + 32'(4 * (i - gs));
            vectors++;
            if (got_pc[i] !== e || got_data[i] !== word_of(e)) begin
                $display("FAIL inflight_word #%0d: got pc=%h data=%h, required pc=%h data=%h", i - gs, got_pc[i], got_data[i], e, word_of(e)); miscompares++;
            end
        end
    endtask

    task automatic test_redirect_collide();
        int gs;
        int is;
        int n;
        lat = 1;
        apply_reset();
        id_ready = 1'b1;
        n = 0;
        while (!(ins_valid && imem_rvalid) && n < 50) begin @(posedge clk); #2; n++; end
        vectors++;
        if (!(ins_valid && imem_rvalid)) begin $display("FAIL collide_wait: got valid=%b rvalid=%b, required 1/1", ins_valid, imem_rvalid); miscompares++; end
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        gs = got_pc.size();
        @(posedge clk);
        #2;
        redirect = 1'b0;
        vectors++;
        if (ins_valid !== 1'b0 || imem_req !== 1'b0) begin
            $display("FAIL collide_flush: got valid=%b req=%b, required 0/0", ins_valid, imem_req); miscompares++;
        end
        is = iss_q.size();
        repeat (20) @(posedge clk);
        vectors++;
        if (iss_q.size() <= is || iss_q[is] !== 32'h100) begin
            $display("FAIL collide_first_addr: got %h, required 100", (iss_q.size() > is) ? iss_q[is] : 32'hFFFF_FFFF); miscompares++;
        end
        for (int i = gs; i < got_pc.size(); i++) begin
            logic [31:0] e;
            e = 32'h100 + 32'(4 * (i - gs));
            vectors++;
            if (got_pc[i] !== e || got_data[i] !== word_of(e)) begin
                $display("FAIL collide_word #%0d: got pc=%h data=%h, required pc=%h data=%h", i - gs, got_pc[i], got_data[i], e, word_of(e)); miscompares++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int gs;
        lat = 2;
        apply_reset();
        id_ready = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        @(posedge clk);
        #2;
        redirect_pc = 32'h302;
        gs = got_pc.size();
        @(posedge clk);
        #2;
        redirect = 1'b0;
        repeat (25) @(posedge clk);
        vectors++;
        if (got_pc.size() - gs < 5) begin $display("FAIL b2b_liveness: got %0d words, required >=5", got_pc.size() - gs); miscompares++; end
        for (int i = gs; i < got_pc.size(); i++) begin
            logic [31:0] e;
            e = 32'h300 + 32'(4 * (i - gs));
            vectors++;
            if (got_pc[i] !== e || got_data[i] !== word_of(e)) begin
                $display("FAIL b2b_word #%0d: got pc=%h data=%h, required pc=%h data=%h", i - gs, got_pc[i], got_data[i], e, word_of(e)); miscompares++;
            end
        end
    endtask

    task automatic test_async_reset();
        int gs;
        int is;
        int n;
        lat = 3;
        apply_reset();
        id_ready = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        n = 0;
        while (mq_addr.size() != 2 && n < 50) begin @(posedge clk); #2; n++; end
        #1;
        arst = 1'b1;
        #1;
        vectors++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || ins_valid !== 1'b0 || ins_data !== 32'h0 || ins_pc !== 32'h0) begin
            $display("FAIL async_reset: got req=%b addr=%h valid=%b data=%h pc=%h, required all 0", imem_req, imem_addr, ins_valid, ins_data, ins_pc); miscompares++;
        end
        @(posedge clk);
        @(posedge clk);
        #2;
        gs = got_pc.size();
        is = iss_q.size();
        arst = 1'b0;
        repeat (20) @(posedge clk);
        vectors++;
        if (iss_q.size() <= is || iss_q[is] !== 32'h0) begin
            $display("FAIL async_restart_addr: got %h, required 0", (iss_q.size() > is) ? iss_q[is] : 32'hFFFF_FFFF); miscompares++;
        end
        vectors++;
        if (got_pc.size() - gs < 4) begin $display("FAIL async_liveness: got %0d words, required >=4", got_pc.size() - gs); miscompares++; end
        for (int i = gs; i < got_pc.size(); i++) begin
            logic [31:0] e;
            e = 32'(4 * (i - gs));
            vectors++;
            if (got_pc[i] !== e || got_data[i] !== word_of(e)) begin
                $display("FAIL async_word #%0d: got pc=%h data=%h, required pc=%h data=%h", i - gs, got_pc[i], got_data[i], e, word_of(e)); miscompares++;
            end
        end
    endtask

    task automatic test_random();
        int gs;
        int gap;
        lat = 1;
        apply_reset();
        gs  = got_pc.size();
        gap = 0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #2;
            id_ready = ($urandom_range(0, 3) != 0);
            if (gap > 12 && $urandom_range(0, 7) == 0) begin
                redirect    = 1'b1;
                redirect_pc = $urandom;
                lat         = $urandom_range(1, 3);
                gap         = 0;
            end else begin
                redirect = 1'b0;
                gap++;
            end
        end
        @(posedge clk);
        #2;
        redirect = 1'b0;
        repeat (10) @(posedge clk);
        vectors++;
        if (got_pc.size() - gs < 100) begin $display("FAIL random_liveness: got %0d words, required >=100", got_pc.size() - gs); miscompares++; end
        for (int i = gs; i < got_pc.size(); i++) begin
            logic [31:0] e;
            e = got_base[i] + 32'(4 * got_k[i]);
            vectors++;
            if (got_pc[i] !== e || got_data[i] !== word_of(e)) begin
                $display("FAIL random_word #%0d: got pc=%h data=%h, required pc=%h data=%h", i - gs, got_pc[i], got_data[i], e, word_of(e)); miscompares++;
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0]  adr_q[$];
        logic [7:0]  p_q[$];
        logic [31:0] d_q[$];
        apply_reset();
        repeat (24) begin
            @(negedge clk);
            if (req8) adr_q.push_back(addr8);
            if (valid8) begin
                p_q.push_back(pc8);
                d_q.push_back(data8);
            end
        end
        vectors++;
        if (adr_q.size() < 3 || p_q.size() < 6) begin
            $display("FAIL wrap_liveness: got %0d addrs %0d words, required >=3/>=6", adr_q.size(), p_q.size()); miscompares++;
        end
        for (int i = 0; i < adr_q.size(); i++) begin
            logic [7:0] e;
            e = 8'hF8 + 8'(4 * i);
            vectors++;
            if (adr_q[i] !== e) begin $display("FAIL wrap_addr #%0d: got %h, required %h", i, adr_q[i], e); miscompares++; end
        end
        for (int i = 0; i < p_q.size(); i++) begin
            logic [7:0] e;
            e = 8'hF8 + 8'(4 * i);
            vectors++;
            if (p_q[i] !== e || d_q[i] !== word_of({24'h0, e})) begin
                $display("FAIL wrap_word #%0d: got pc=%h data=%h, required pc=%h data=%h", i, p_q[i], d_q[i], e, word_of({24'h0, e})); miscompares++;
            end
        end
    endtask

    initial begin
        arst        = 1'b1;
        id_ready    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_collide();
        test_back_to_back();
        test_async_reset();
        test_random();
        test_wrap();
        vectors++;
        if (idle_bad !== 0) begin
            $display("FAIL idle_outputs: got %0d cycles with nonzero data/pc while invalid, required 0", idle_bad); miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
